// File: rtl/seg_scan_if.sv
// Display back-end bus: segment/mode/alarm inputs from the watch top and the
// multiplexed display, LED and buzzer drives going out to the board.
interface seg_scan_if;
  logic [47:0] seg_i;
  logic [7:0]  mode_i;
  logic        alarm_i;
  logic [5:0]  blink_mask_i;
  logic [7:0]  seg_o;
  logic [5:0]  an_o;
  logic [7:0]  led_o;
  logic        buzz_o;

  modport master (
    output seg_i, mode_i, alarm_i, blink_mask_i,
    input  seg_o, an_o, led_o, buzz_o
  );

  modport slave (
    input  seg_i, mode_i, alarm_i, blink_mask_i,
    output seg_o, an_o, led_o, buzz_o
  );
endinterface

// File: rtl/seg_scan.sv
// Six-digit common-anode 7-segment scanner with guard time, per-digit blink,
// frame-synchronous snapshot, registered mode LEDs and a cadenced buzzer.
module seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 50,
  parameter int BUZZ_DIV     = 12500
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C    = CW'(GUARD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TONE_LAST  = TW'(BUZZ_DIV - 1);

  logic [CW-1:0]   cnt;
  logic [2:0]      digit;
  logic [FW-1:0]   frame_cnt;
  logic            phase;
  logic [5:0][7:0] snap;
  logic [5:0]      mask;
  logic [TW-1:0]   tone_cnt;
  logic            tone;

  logic       slot_end, frame_end, blank;
  logic [5:0] an_nxt;
  logic [7:0] seg_nxt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (digit == 3'd5);

  // Guard window and blanked digits both turn every anode off, so at most
  // one anode is ever driven low.
  always_comb begin
    blank   = (cnt < GUARD_C) || (mask[digit] && phase);
    an_nxt  = 6'h3F;
    seg_nxt = 8'hFF;
    if (!blank) begin
      an_nxt  = ~(6'b1 << digit);
      seg_nxt = ~snap[digit];
    end
  end

  // Scan position, blink phase and the tear-free snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      snap      <= '0;
      mask      <= '0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        digit <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
      if (frame_end) begin
        snap <= bus.seg_i;
        mask <= bus.blink_mask_i;
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Tone generator restarts from a known low level on every alarm rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (!bus.alarm_i) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an_o   <= 6'h3F;
      bus.seg_o  <= 8'hFF;
      bus.led_o  <= 8'h00;
      bus.buzz_o <= 1'b0;
    end else begin
      bus.an_o   <= an_nxt;
      bus.seg_o  <= seg_nxt;
      bus.led_o  <= bus.mode_i;
      bus.buzz_o <= bus.alarm_i & tone & ~phase;
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a small scan geometry: 4-cycle slots,
// 1-cycle guard, 2-frame blink half-period, 3-cycle tone half-period.
module tb_seg_scan;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;
  int   edges  = 0;
  logic an_viol = 1'b0;

  localparam logic [47:0] PAT = 48'h3F06_5B4F_6664;
  logic [11:0] bz_tab = 12'b111_000_111_000;

  seg_scan_if bus();

  seg_scan #(
    .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2), .BUZZ_DIV(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && !$isunknown(bus.an_o) && ($countones(~bus.an_o) > 1))
      an_viol = 1'b1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  // Output after edge k reflects scan state k-1 counted from reset release.
  task automatic goto_state(input int s);
    while (edges < s + 1) tick();
  endtask

  task automatic rst_on();
    #1 rst = 1'b1;
  endtask

  task automatic rst_off();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    edges = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.seg_i        = PAT;
    bus.mode_i       = 8'h00;
    bus.alarm_i      = 1'b0;
    bus.blink_mask_i = 6'h00;
    @(negedge clk);

    // Reset values
    rst_on();
    #1;
    chk("rst_an",   bus.an_o,   6'h3F);
    chk("rst_seg",  bus.seg_o,  8'hFF);
    chk("rst_led",  bus.led_o,  8'h00);
    chk("rst_buzz", bus.buzz_o, 1'b0);
    rst_off();

    // Mode LEDs follow with one cycle of delay
    tick();
    chk("led_0", bus.led_o, 8'h00);
    bus.mode_i = 8'h01;
    tick();
    chk("led_1", bus.led_o, 8'h01);
    bus.mode_i = 8'h02;
    tick();
    chk("led_2", bus.led_o, 8'h02);
    bus.mode_i = 8'h40;
    tick();
    chk("led_40", bus.led_o, 8'h40);

    // Frame 0 is blank (empty snapshot); frame 1 shows the pattern
    goto_state(5);
    chk("f0_an",  bus.an_o,  6'h3D);
    chk("f0_seg", bus.seg_o, 8'hFF);
    goto_state(24);
    chk("f1_guard_an",  bus.an_o,  6'h3F);
    chk("f1_guard_seg", bus.seg_o, 8'hFF);
    goto_state(25);
    chk("f1_d0_an",  bus.an_o,  6'h3E);
    chk("f1_d0_seg", bus.seg_o, 8'h9B);
    goto_state(34);
    chk("f1_d2_an",  bus.an_o,  6'h3B);
    chk("f1_d2_seg", bus.seg_o, 8'hB0);
    goto_state(45);
    chk("f1_d5_an",  bus.an_o,  6'h1F);
    chk("f1_d5_seg", bus.seg_o, 8'hC0);

    // Mid-frame seg_i change stays hidden until the next frame
    goto_state(56);
    bus.seg_i = {6{8'hFF}};
    goto_state(65);
    chk("tear_d4_an",  bus.an_o,  6'h2F);
    chk("tear_d4_seg", bus.seg_o, 8'hF9);
    goto_state(73);
    chk("new_d0_an",  bus.an_o,  6'h3E);
    chk("new_d0_seg", bus.seg_o, 8'h00);
    goto_state(93);
    chk("new_d5_seg", bus.seg_o, 8'h00);

    // Blink on digit 2
    bus.seg_i        = PAT;
    bus.blink_mask_i = 6'b000100;
    rst_on();
    rst_off();
    goto_state(33);
    chk("blk_f1_an",  bus.an_o,  6'h3B);
    chk("blk_f1_seg", bus.seg_o, 8'hB0);
    goto_state(57);
    chk("blk_f2_an",  bus.an_o,  6'h3F);
    chk("blk_f2_seg", bus.seg_o, 8'hFF);
    goto_state(61);
    chk("blk_f2_d3_an",  bus.an_o,  6'h37);
    chk("blk_f2_d3_seg", bus.seg_o, 8'hA4);
    goto_state(82);
    chk("blk_f3_an", bus.an_o, 6'h3F);
    goto_state(105);
    chk("blk_f4_an",  bus.an_o,  6'h3B);
    chk("blk_f4_seg", bus.seg_o, 8'hB0);
    goto_state(129);
    chk("blk_f5_an", bus.an_o, 6'h3B);

    // Alarm buzzer cadence
    bus.blink_mask_i = 6'h00;
    rst_on();
    rst_off();
    tick();
    tick();
    bus.alarm_i = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("buzz_a%0d", j), bus.buzz_o, bz_tab[j-1]);
    end
    goto_state(48);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk($sformatf("buzz_ph1_%0d", j), bus.buzz_o, 1'b0);
    end
    goto_state(99);
    bus.alarm_i = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk($sformatf("buzz_off%0d", j), bus.buzz_o, 1'b0);
    end
    bus.alarm_i = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("buzz_b%0d", j), bus.buzz_o, bz_tab[j-1]);
    end

    // Asynchronous reset mid-slot with alarm held
    goto_state(126);
    chk("pre_rst_an",  bus.an_o,  6'h3D);
    chk("pre_rst_seg", bus.seg_o, 8'h99);
    #3 rst = 1'b1;
    #1;
    chk("arst_an",   bus.an_o,   6'h3F);
    chk("arst_seg",  bus.seg_o,  8'hFF);
    chk("arst_led",  bus.led_o,  8'h00);
    chk("arst_buzz", bus.buzz_o, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    edges = 0;
    tick();
    chk("post_rst_guard", bus.an_o, 6'h3F);
    chk("post_rst_buzz",  bus.buzz_o, 1'b0);
    tick();
    chk("post_rst_d0", bus.an_o, 6'h3E);

    chk("an_onehot", an_viol, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
